ctrl_decoder: RTL
=================

Name: ctrl_decoder

Overview:
- Sequencing control unit for the 4-bit Digital 1 processor; the consumer side of the ALU interface.
- Fetches a 12-bit instruction word from program ROM and decodes it into the ALU function select, operand-B source and write strobes.
- Latches the ALU carry/zero outputs into a flag register and resolves conditional jumps by updating the program counter.
- Sits between program ROM, data memory/IO and the datapath (accumulator + ALU).

Parameters:
PC_W, 8, program counter width; jump targets are instr[PC_W-1:0] (PC_W <= 8)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
instr  in  12  instruction word from ROM: opcode = instr[11:8], operand = instr[7:0]
instr_valid  in  1  ROM data for current pc is valid
alu_carry  in  1  ALU carry/borrow output (result bit 4)
alu_zero  in  1  ALU zero output
pc  out  PC_W  program counter / ROM address
alu_f  out  3  ALU function: 000 pass A, 001 A-B, 010 pass B, 011 A+B, 100 NAND
b_sel  out  2  operand B source: 00 immediate instr[3:0], 01 data memory, 10 input port
imm  out  4  instr[3:0] of latched IR
mem_addr  out  4  data memory address = IR[3:0]
acc_we  out  1  accumulator write strobe
mem_we  out  1  data memory write strobe (ST)
out_we  out  1  output port write strobe (OUT)
flag_c  out  1  registered carry flag
flag_z  out  1  registered zero flag
halted  out  1  high in HALT state

Behaviour:
- Reset (async, immediate): pc=RESET_PC, IR=0, flag_c=0, flag_z=0, state=FETCH, all strobes 0, alu_f=000, b_sel=00, halted=0.
- FSM states: FETCH, EXEC, HALT.
- FETCH: strobes 0. When instr_valid=1, latch IR<=instr and go to EXEC. Otherwise stay in FETCH with pc unchanged.
- EXEC: lasts exactly one cycle. alu_f, b_sel and strobes are decoded combinationally from IR; flags and pc update on the closing edge; next state is FETCH, or HALT for opcode F.
- Minimum throughput: 2 cycles per instruction.
- Opcode decode (alu_f / b_sel / strobe / flags updated):
  - 0 NOP: 000 / – / none / no
  - 1 LIT: 010 / 00 / acc_we / no
  - 2 ADDI: 011 / 00 / acc_we / C,Z
  - 3 ADDM: 011 / 01 / acc_we / C,Z
  - 4 NANDI: 100 / 00 / acc_we / C,Z
  - 5 NANDM: 100 / 01 / acc_we / C,Z
  - 6 CMPI: 001 / 00 / none / C,Z
  - 7 CMPM: 001 / 01 / none / C,Z
  - 8 LD: 010 / 01 / acc_we / no
  - 9 ST: 000 / – / mem_we / no
  - A IN: 010 / 10 / acc_we / no
  - B OUT: 000 / – / out_we / no
  - C JMP, D JZ, E JC: 000 / – / none / no
  - F HALT
- Flag update: flag_c<=alu_carry and flag_z<=alu_zero, sampled at the end of EXEC. NAND therefore always clears C.
- PC update at end of EXEC:
  - Taken jump: pc<=IR[PC_W-1:0]. JMP is always taken; JZ is taken if flag_z=1; JC is taken if flag_c=1.
  - Jumps test the flag values registered before this instruction.
  - Otherwise pc<=pc+1, wrapping modulo 2^PC_W (max -> 0).
- Outside EXEC, alu_f=000, b_sel=00, all strobes 0.
- HALT: pc, flags and IR frozen; halted=1; instr_valid ignored; exit only via reset.
- Reset asserted mid-EXEC: strobes drop immediately; no memory/ACC write is considered committed.
- instr_valid held high continuously: no double-fetch, because it is sampled only in FETCH.

Test Plan:
- Reset then instr=0x1_05 (LIT 5) with instr_valid=1 -> EXEC cycle shows alu_f=010, b_sel=00, imm=5, acc_we=1; pc goes 0->1; flags stay 0.
- ADDI with alu_carry=1, alu_zero=1 -> flag_c=1, flag_z=1 after EXEC. Following NANDI with alu_carry=0, alu_zero=0 -> both flags clear.
- CMPI sets flag_z=1, then JZ 0x40 -> pc=0x40. Repeat with flag_z=0 -> pc increments by 1. JC behaves likewise on flag_c.
- pc=0xFF executing NOP -> pc wraps to 0x00. JMP 0x10 from pc=0x05 -> pc=0x10.
- instr_valid held low for 5 cycles in FETCH -> pc stable, no strobes; fetch proceeds on the cycle valid rises.
- HALT (0xF00) -> halted=1 and pc frozen for 10 cycles with instr_valid=1. Asserting reset mid-EXEC of ST -> mem_we drops asynchronously, pc=RESET_PC.

Source files
------------

// File: rtl/ctrl_decoder_if.sv
// Bus between the Digital 1 sequencer and its ROM / ALU / memory environment.
// The sequencer itself connects through the slave modport.
interface ctrl_decoder_if #(
  parameter int PC_W = 8
);
  logic [11:0]     instr;
  logic            instr_valid;
  logic            alu_carry;
  logic            alu_zero;
  logic [PC_W-1:0] pc;
  logic [2:0]      alu_f;
  logic [1:0]      b_sel;
  logic [3:0]      imm;
  logic [3:0]      mem_addr;
  logic            acc_we;
  logic            mem_we;
  logic            out_we;
  logic            flag_c;
  logic            flag_z;
  logic            halted;

  modport master (
    output instr, instr_valid, alu_carry, alu_zero,
    input  pc, alu_f, b_sel, imm, mem_addr, acc_we, mem_we, out_we,
           flag_c, flag_z, halted
  );

  modport slave (
    input  instr, instr_valid, alu_carry, alu_zero,
    output pc, alu_f, b_sel, imm, mem_addr, acc_we, mem_we, out_we,
           flag_c, flag_z, halted
  );
endinterface

// File: rtl/ctrl_decoder.sv
// Fetch/execute sequencer for the 4-bit Digital 1 processor: fetches a 12-bit
// instruction, drives the ALU controls for one EXEC cycle, then updates flags and pc.
module ctrl_decoder #(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0
) (
  input  logic          clk,
  input  logic          reset,
  ctrl_decoder_if.slave bus
);

  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

  typedef struct packed {
    logic [2:0] f;
    logic [1:0] b;
    logic       acc;
    logic       mem;
    logic       out;
    logic       upd;
  } dec_t;

  state_t          state;
  logic [11:0]     ir;
  logic [PC_W-1:0] pc;
  logic            fc;
  logic            fz;
  logic [2:0]      alu_f;
  logic [1:0]      b_sel;
  logic            acc_we;
  logic            mem_we;
  logic            out_we;
  logic            upd_flags;
  logic            jump_taken;
  dec_t            dec;

  function automatic dec_t decode(input logic [3:0] op);
    dec_t d;
    d = '0;
    case (op)
      4'h1: begin d.f = 3'b010; d.b = 2'b00; d.acc = 1'b1; end
      4'h2: begin d.f = 3'b011; d.b = 2'b00; d.acc = 1'b1; d.upd = 1'b1; end
      4'h3: begin d.f = 3'b011; d.b = 2'b01; d.acc = 1'b1; d.upd = 1'b1; end
      4'h4: begin d.f = 3'b100; d.b = 2'b00; d.acc = 1'b1; d.upd = 1'b1; end
      4'h5: begin d.f = 3'b100; d.b = 2'b01; d.acc = 1'b1; d.upd = 1'b1; end
      4'h6: begin d.f = 3'b001; d.b = 2'b00; d.upd = 1'b1; end
      4'h7: begin d.f = 3'b001; d.b = 2'b01; d.upd = 1'b1; end
      4'h8: begin d.f = 3'b010; d.b = 2'b01; d.acc = 1'b1; end
      4'h9: d.mem = 1'b1;
      4'hA: begin d.f = 3'b010; d.b = 2'b10; d.acc = 1'b1; end
      4'hB: d.out = 1'b1;
      default: d = '0;
    endcase
    return d;
  endfunction

  // Jumps look at the flags as they stood before this instruction executes.
  always_comb begin
    dec        = decode(bus.instr[11:8]);
    jump_taken = 1'b0;
    case (ir[11:8])
      4'hC:    jump_taken = 1'b1;
      4'hD:    jump_taken = fz;
      4'hE:    jump_taken = fc;
      default: jump_taken = 1'b0;
    endcase
  end

  // Decode is captured alongside IR so the EXEC-cycle controls come straight from
  // flops; the async reset clears them immediately, so a reset mid-EXEC commits nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      ir        <= '0;
      pc        <= PC_W'(RESET_PC);
      fc        <= 1'b0;
      fz        <= 1'b0;
      alu_f     <= 3'b000;
      b_sel     <= 2'b00;
      acc_we    <= 1'b0;
      mem_we    <= 1'b0;
      out_we    <= 1'b0;
      upd_flags <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.instr_valid) begin
            ir        <= bus.instr;
            alu_f     <= dec.f;
            b_sel     <= dec.b;
            acc_we    <= dec.acc;
            mem_we    <= dec.mem;
            out_we    <= dec.out;
            upd_flags <= dec.upd;
            state     <= EXEC;
          end
        end
        EXEC: begin
          alu_f     <= 3'b000;
          b_sel     <= 2'b00;
          acc_we    <= 1'b0;
          mem_we    <= 1'b0;
          out_we    <= 1'b0;
          upd_flags <= 1'b0;
          if (upd_flags) begin
            fc <= bus.alu_carry;
            fz <= bus.alu_zero;
          end
          pc    <= jump_taken ? ir[PC_W-1:0] : pc + PC_W'(1);
          state <= (ir[11:8] == 4'hF) ? HALT : FETCH;
        end
        HALT: begin
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign bus.pc       = pc;
  assign bus.alu_f    = alu_f;
  assign bus.b_sel    = b_sel;
  assign bus.imm      = ir[3:0];
  assign bus.mem_addr = ir[3:0];
  assign bus.acc_we   = acc_we;
  assign bus.mem_we   = mem_we;
  assign bus.out_we   = out_we;
  assign bus.flag_c   = fc;
  assign bus.flag_z   = fz;
  assign bus.halted   = (state == HALT);

endmodule
